bin_morph3x3: RTL
=================

Name: bin_morph3x3

Overview:
- Consumer end of the three-row binary line-buffer chain: receives the live pixel and the two delayed row taps, and assembles a 3x3 window.
- Applies a selectable binary morphology operator and emits one result pixel per interior image position, with an aligned valid strobe and an end-of-frame pulse.
- Sits directly after the line-buffer block in the binary image path, ahead of downstream feature extraction.

Parameters:
- IMG_W, 640, pixels per line (>=3); column counter width = clog2(IMG_W).
- IMG_H, 480, lines per frame (>=3); row counter width = clog2(IMG_H).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- ce  in  1  pixel-valid strobe, same ce that advances the line buffers
- row0  in  1  current pixel (r,c), the d input of the line buffers
- row1  in  1  pixel (r-1,c), first line-buffer tap
- row2  in  1  pixel (r-2,c), second line-buffer tap
- mode  in  2  00 pass centre, 01 erode, 10 dilate, 11 majority
- pix_out  out  1  morphology result
- pix_valid  out  1  pix_out valid this cycle
- frame_done  out  1  one-cycle pulse after the last result of a frame

Behaviour:
- Reset: rst_n low at a rising edge clears all of the following to 0:
  - col_cnt, row_cnt
  - all 9 window bits
  - mode_q
  - pix_out, pix_valid, frame_done
- Reset mid-frame discards the partial frame. The first ce after release is pixel (0,0).
- ce low: counters, window and mode_q hold. pix_valid=0 and frame_done=0 on the next edge. pix_out holds its last value.
- Window (on each ce beat):
  - Three columns per row; column 2 <= {row2,row1,row0}, column 1 <= old column 2, column 0 <= old column 1.
  - Centre = column 1, middle row = pixel (r-1,c-1).
- Counters (on each ce beat):
  - col_cnt increments; at IMG_W-1 it wraps to 0 and row_cnt increments.
  - row_cnt wraps IMG_H-1 -> 0 when col_cnt wraps.
  - (r,c) denotes the counter values before the increment.
- Mode latch: mode_q <= mode on the ce beat with r=0,c=0. mode changes mid-frame have no effect until the next frame.
- Result qualification: a ce beat with r>=2 and c>=2 produces a result.
  - It is computed from the window including that beat's column.
  - It is registered: pix_out/pix_valid assert on the edge following the beat, latency 1 clk.
  - Beats with r<2 or c<2 produce pix_valid=0; these are border positions, no output.
- Output count per frame = (IMG_W-2)*(IMG_H-2).
- Operators (on the 9 window bits):
  - 00: centre bit.
  - 01: AND of all 9.
  - 10: OR of all 9.
  - 11: popcount (4-bit, 0..9) >= 5.
- frame_done: asserts together with the pix_valid of the beat r=IMG_H-1, c=IMG_W-1, for exactly one cycle.
- Back-to-back frames: the next ce after the last beat is (0,0) of the new frame. No gap is required.
- No backpressure; the downstream must accept every pix_valid.

Test Plan:
- Reset then 8x6 frame (IMG_W=8, IMG_H=6), all ones, mode=01, continuous ce -> 24 pix_valid pulses, all pix_out=1, each 1 clk after its beat; frame_done coincident with the 24th.
- Same frame, single 1 at (3,3), otherwise 0:
  - mode=10 -> pix_out=1 exactly at centres (2..4,2..4), 9 ones.
  - mode=01 -> all 0.
  - mode=00 -> single 1 at centre (3,3).
- Majority, mode=11, with rows 2..3 fully 1 -> centre row 2 (window 6 ones) =1, centre row 1 (window 3 ones) =0.
- ce toggled 1/0 every cycle through a full frame -> identical pix_out sequence to the continuous-ce run; pix_valid never high on a cycle following ce=0.
- mode changed from 01 to 10 at beat (3,4) -> remainder of frame stays erode; next frame uses dilate.
- rst_n low 1 clk at beat (4,5), then restart a full frame -> no pix_valid/frame_done during reset; new frame yields exactly 24 outputs and one frame_done.

Source files
------------

// File: rtl/bin_morph3x3.sv
// Binary 3x3 morphology stage at the consumer end of the line-buffer chain.
// It builds a 3x3 window from the live pixel and two row taps, then applies
// the operator that was latched at the start of the frame. It emits one
// registered result for each interior image position.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - synchronous active-low reset
//   ce         - pixel-valid strobe, shared with the line buffers
//   row0       - pixel (r,c), live input
//   row1       - pixel (r-1,c), first line-buffer tap
//   row2       - pixel (r-2,c), second line-buffer tap
//   mode       - 00 centre, 01 erode, 10 dilate, 11 majority
//   pix_out    - morphology result
//   pix_valid  - pix_out is valid this cycle
//   frame_done - one-cycle pulse alongside the last result of a frame
module bin_morph3x3 #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       row0,
  input  logic       row1,
  input  logic       row2,
  input  logic [1:0] mode,
  output logic       pix_out,
  output logic       pix_valid,
  output logic       frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  // Window columns, oldest first; each column is {row2,row1,row0}.
  logic [2:0]    win0_q, win0_d, win1_q, win1_d, win2_q, win2_d;
  logic [1:0]    mode_q, mode_d;
  logic          pix_out_q, pix_out_d;
  logic          pix_valid_q, pix_valid_d;
  logic          frame_done_q, frame_done_d;

  logic [2:0]    col_new;
  logic [8:0]    win_next;
  logic [3:0]    ones;
  logic          result;
  logic          interior;
  logic          last_beat;

  assign col_new  = {row2, row1, row0};
  // The result uses the window as it will be after this beat's shift.
  assign win_next = {win1_q, win2_q, col_new};

  always_comb begin
    ones = '0;
    for (int i = 0; i < 9; i++) begin
      ones = ones + {3'b000, win_next[i]};
    end
  end

  always_comb begin
    unique case (mode_q)
      2'b00:   result = win2_q[1];  // becomes column 1, middle row
      2'b01:   result = &win_next;
      2'b10:   result = |win_next;
      default: result = (ones >= 4'd5);
    endcase
  end

  assign interior  = (row_cnt_q >= RW'(2)) && (col_cnt_q >= CW'(2));
  assign last_beat = (row_cnt_q == RowLast) && (col_cnt_q == ColLast);

  always_comb begin
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    win0_d       = win0_q;
    win1_d       = win1_q;
    win2_d       = win2_q;
    mode_d       = mode_q;
    pix_out_d    = pix_out_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (ce) begin
      if (col_cnt_q == ColLast) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == RowLast) ? '0 : row_cnt_q + RW'(1);
      end else begin
        col_cnt_d = col_cnt_q + CW'(1);
      end
      win0_d = win1_q;
      win1_d = win2_q;
      win2_d = col_new;
      if ((row_cnt_q == '0) && (col_cnt_q == '0)) begin
        mode_d = mode;
      end
      if (interior) begin
        pix_out_d    = result;
        pix_valid_d  = 1'b1;
        frame_done_d = last_beat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      win0_q       <= '0;
      win1_q       <= '0;
      win2_q       <= '0;
      mode_q       <= '0;
      pix_out_q    <= 1'b0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      win0_q       <= win0_d;
      win1_q       <= win1_d;
      win2_q       <= win2_d;
      mode_q       <= mode_d;
      pix_out_q    <= pix_out_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_out    = pix_out_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;

endmodule
